// File: rtl/ascon_pkg.sv
// ascon_pkg: shared mode encodings, rate constants and absorb FSM states.
package ascon_pkg;
  typedef enum logic [1:0] {
    MODE_AEAD128 = 2'b00,
    MODE_HASH256 = 2'b01,
    MODE_XOF128  = 2'b10,
    MODE_CXOF128 = 2'b11
  } mode_e;
  localparam int RATE_AEAD = 16;
  localparam int RATE_HASH = 8;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_DONE, S_ERR} state_e;
endpackage

// File: rtl/ascon_absorb_pacer.sv
// ascon_absorb_pacer: permutation-latency down-counter, loaded at issue, expired at zero.
module ascon_absorb_pacer #(
  parameter int LAT = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_expired
);
  localparam int CW = LAT > 1 ? $clog2(LAT) : 1;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_cnt <= '0;
    else r_cnt <= i_load ? CW'(LAT - 1) : (r_cnt != '0 ? r_cnt - 1'b1 : r_cnt);
  assign o_expired = r_cnt == '0;
endmodule

// File: rtl/ascon_absorb_ctrl.sv
// ascon_absorb_ctrl: absorb sequencer; pulls rate-sized words and strobes the
// datapath once per block, pacing blocks against the permutation latency.
module ascon_absorb_ctrl
  import ascon_pkg::*;
#(
  parameter int               PERM_LAT = 1,
  parameter int               LEN_W    = 32,
  parameter logic [LEN_W-1:0] MAX_LEN  = 32'hFFFF_FF00
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [1:0]       i_mode,
  input  logic [LEN_W-1:0] i_msg_len,
  input  logic [127:0]     i_s_data,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic             o_dp_process_en,
  output logic [1:0]       o_dp_sel_type,
  output logic [LEN_W-1:0] o_dp_data_length,
  output logic [LEN_W-1:0] o_dp_data_position,
  output logic [127:0]     o_dp_data,
  output logic             o_dp_state_sel,
  input  logic             i_dp_process_err
);
  state_e           r_state, w_next;
  logic [1:0]       r_mode;
  logic [LEN_W-1:0] r_len, r_pos, w_rem, w_rate;
  logic [LEN_W:0]   w_sum;
  logic [127:0]     r_data;
  logic             r_err, r_sel;
  logic             w_hash, w_last, w_ready, w_hs, w_expired;
  logic             w_latch, w_set_err, w_load, w_adv;
  assign w_hash  = r_mode != MODE_AEAD128;
  assign w_rate  = w_hash ? LEN_W'(RATE_HASH) : LEN_W'(RATE_AEAD);
  assign w_rem   = r_len - r_pos;
  assign w_last  = w_rem < w_rate;
  assign w_sum   = {1'b0, r_pos} + {1'b0, w_rate};
  // ready is withheld under abort so no word is consumed by a cancelled job
  assign w_ready = r_state == S_FETCH && w_rem != '0 && !i_abort;
  assign w_hs    = w_ready && i_s_valid;
  ascon_absorb_pacer #(.LAT(PERM_LAT)) u_pacer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (w_load),
    .o_expired(w_expired)
  );
  always_comb begin
    w_next    = r_state;
    w_latch   = 1'b0;
    w_set_err = 1'b0;
    w_load    = 1'b0;
    w_adv     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_latch   = i_start && i_msg_len <= MAX_LEN;
        w_set_err = i_start && i_msg_len > MAX_LEN;
        w_next    = w_latch ? S_FETCH : S_IDLE;
      end
      S_FETCH: w_next = (w_rem == '0 || w_hs) ? S_ISSUE : S_FETCH;
      S_ISSUE: begin
        w_set_err = i_dp_process_err;
        w_load    = !i_dp_process_err;
        w_next    = i_dp_process_err ? S_ERR : S_WAIT;
      end
      S_WAIT: begin
        w_set_err = w_expired && !w_last && w_sum[LEN_W];
        w_adv     = w_expired && !w_last && !w_sum[LEN_W];
        w_next    = !w_expired ? S_WAIT : w_last ? S_DONE : w_sum[LEN_W] ? S_ERR : S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
    if (i_abort) begin
      w_next    = S_IDLE;
      w_latch   = 1'b0;
      w_set_err = 1'b0;
      w_load    = 1'b0;
      w_adv     = 1'b0;
    end
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_state <= S_IDLE;
    else r_state <= w_next;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_mode <= '0;
      r_len  <= '0;
      r_pos  <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
      r_sel  <= 1'b0;
    end else begin
      if (w_latch) begin
        r_mode <= i_mode;
        r_len  <= i_msg_len;
        r_pos  <= '0;
        r_err  <= 1'b0;
      end else if (w_set_err) r_err <= 1'b1;
      if (w_adv) r_pos <= w_sum[LEN_W-1:0];
      if (r_state == S_FETCH && w_rem == '0) r_data <= '0;
      else if (w_hs) r_data <= w_hash ? {64'b0, i_s_data[63:0]} : i_s_data;
      r_sel <= w_next != S_IDLE && (r_sel || r_state == S_ISSUE);
    end
  assign o_s_ready          = w_ready;
  assign o_busy             = r_state != S_IDLE;
  assign o_done             = r_state == S_DONE;
  assign o_err              = r_err;
  assign o_dp_process_en    = r_state == S_ISSUE;
  assign o_dp_sel_type      = r_mode;
  assign o_dp_data_length   = r_len;
  assign o_dp_data_position = r_pos;
  assign o_dp_data          = r_data;
  assign o_dp_state_sel     = r_sel;
endmodule

// File: tb/tb_ascon_absorb_ctrl.sv
// tb_ascon_absorb_ctrl: directed checks of two controllers (PERM_LAT 1 and 4)
// driven by shared stimulus; a negedge monitor logs pulses, handshakes and done.
module tb_ascon_absorb_ctrl;
  logic clk = 0, rst = 1, start = 0, abort = 0, s_valid = 0, dperr0 = 0, dperr4 = 0, clr = 0;
  logic [1:0] mode = 0;
  logic [31:0] msg_len = 0;
  logic [127:0] s_data = 0;
  logic rdy0, busy0, done0, err0, en0, st0, rdy4, busy4, done4, err4, en4, st4;
  logic [1:0] ty0, ty4;
  logic [31:0] len0, pos0, len4, pos4;
  logic [127:0] dat0, dat4;
  int vectors = 0, miscompares = 0, cyc = 0;
  logic [31:0] lp0[$], lp4[$];
  logic [127:0] ld0[$], ld4[$];
  logic ls0[$], ls4[$];
  int lt0[$], lt4[$];
  int hs0 = 0, rc0 = 0, dn0 = 0, dc0 = 0, dn4 = 0;
  localparam logic [127:0] D = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] DH = {64'b0, D[63:0]};
  always #5 clk = ~clk;
  ascon_absorb_ctrl #(.PERM_LAT(1)) u0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_mode(mode),
    .i_msg_len(msg_len), .i_s_data(s_data), .i_s_valid(s_valid), .o_s_ready(rdy0),
    .o_busy(busy0), .o_done(done0), .o_err(err0), .o_dp_process_en(en0),
    .o_dp_sel_type(ty0), .o_dp_data_length(len0), .o_dp_data_position(pos0),
    .o_dp_data(dat0), .o_dp_state_sel(st0), .i_dp_process_err(dperr0));
  ascon_absorb_ctrl #(.PERM_LAT(4)) u4 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_mode(mode),
    .i_msg_len(msg_len), .i_s_data(s_data), .i_s_valid(s_valid), .o_s_ready(rdy4),
    .o_busy(busy4), .o_done(done4), .o_err(err4), .o_dp_process_en(en4),
    .o_dp_sel_type(ty4), .o_dp_data_length(len4), .o_dp_data_position(pos4),
    .o_dp_data(dat4), .o_dp_state_sel(st4), .i_dp_process_err(dperr4));
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (clr) begin
      lp0.delete(); ld0.delete(); ls0.delete(); lt0.delete();
      lp4.delete(); ld4.delete(); ls4.delete(); lt4.delete();
      hs0 = 0; rc0 = 0; dn0 = 0; dc0 = 0; dn4 = 0;
    end else begin
      if (en0) begin lp0.push_back(pos0); ld0.push_back(dat0); ls0.push_back(st0); lt0.push_back(cyc); end
      if (en4) begin lp4.push_back(pos4); ld4.push_back(dat4); ls4.push_back(st4); lt4.push_back(cyc); end
      if (rdy0 && s_valid) hs0++;
      if (rdy0) rc0++;
      if (done0) begin dn0++; dc0 = cyc; end
      if (done4) dn4++;
    end
  end
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic clear();
    clr = 1; @(negedge clk); #1 clr = 0;
  endtask
  task automatic go(input logic [1:0] m, input logic [31:0] l);
    mode = m; msg_len = l; start = 1; step(); start = 0;
  endtask
  task automatic wait_idle();
    for (int k = 0; k < 400 && (busy0 || busy4); k++) step();
    chk("idle_timeout", 128'({busy0, busy4}), 128'd0);
  endtask
  function automatic logic [127:0] outs0();
    return 128'({rdy0, busy0, done0, err0, en0, st0, ty0, len0, pos0, dat0[31:0]}) | 128'(dat0 != 0);
  endfunction
  function automatic logic [127:0] outs4();
    return 128'({rdy4, busy4, done4, err4, en4, st4, ty4, len4, pos4, dat4[31:0]}) | 128'(dat4 != 0);
  endfunction
  initial begin
    step(); step();
    chk("reset_outs0", outs0(), 0);
    chk("reset_outs4", outs4(), 0);
    rst = 0; s_valid = 1; s_data = D;
    // AEAD 20 bytes: blocks at 0 and 16
    clear(); go(2'b00, 20); wait_idle();
    chk("a20_npulse", 128'(lp0.size()), 2);
    chk("a20_pos0", lp0[0], 0);
    chk("a20_pos1", lp0[1], 16);
    chk("a20_words", 128'(hs0), 2);
    chk("a20_data0", ld0[0], D);
    chk("a20_sel", 128'({ls0[0], ls0[1]}), 128'b01);
    chk("a20_spacing", 128'(lt0[1] - lt0[0]), 3);
    chk("a20_done_lat", 128'(dc0 - lt0[1]), 2);
    chk("a20_ndone", 128'(dn0), 1);
    chk("a20_u4_npulse", 128'(lp4.size()), 2);
    // AEAD 32 bytes: trailing empty pad block
    clear(); go(2'b00, 32); wait_idle();
    chk("a32_npulse", 128'(lp0.size()), 3);
    chk("a32_pos2", lp0[2], 32);
    chk("a32_words", 128'(hs0), 2);
    chk("a32_pad_data", ld0[2], 0);
    chk("a32_ndone", 128'(dn0), 1);
    // Hash256 empty message
    clear(); go(2'b01, 0); wait_idle();
    chk("h0_npulse", 128'(lp0.size()), 1);
    chk("h0_pos", lp0[0], 0);
    chk("h0_ready_cycles", 128'(rc0), 0);
    chk("h0_data", ld0[0], 0);
    chk("h0_ndone", 128'(dn0), 1);
    // Hash256 17 bytes on the slow pacer
    clear(); go(2'b01, 17); wait_idle();
    chk("h17_npulse", 128'(lp4.size()), 3);
    chk("h17_pos", 128'({lp4[0], lp4[1], lp4[2]}), 128'({32'd0, 32'd8, 32'd16}));
    chk("h17_gap_ge5", 128'(lt4[1] - lt4[0] >= 5 && lt4[2] - lt4[1] >= 5), 1);
    chk("h17_sel", 128'({ls4[0], ls4[1], ls4[2]}), 128'b011);
    chk("h17_data", ld4[0], DH);
    chk("h17_ndone", 128'(dn4), 1);
    chk("h17_u0_npulse", 128'(lp0.size()), 3);
    // stall the second word for 10 cycles
    clear(); go(2'b00, 20);
    for (int k = 0; k < 20 && hs0 < 1; k++) step();
    chk("stall_first_hs", 128'(hs0), 1);
    s_valid = 0;
    repeat (10) step();
    chk("stall_no_pulse", 128'(lp0.size()), 1);
    chk("stall_ready_held", 128'(rdy0), 1);
    s_valid = 1; wait_idle();
    chk("stall_npulse", 128'(lp0.size()), 2);
    chk("stall_gap", 128'(lt0[1] - lt0[0] >= 10), 1);
    // abort while the slow pacer is in WAIT
    clear(); go(2'b01, 17);
    for (int k = 0; k < 20 && lp4.size() < 1; k++) step();
    step();
    chk("abort_in_wait", 128'({busy4, en4}), 128'b10);
    abort = 1; step(); abort = 0;
    chk("abort_idle", 128'({busy0, busy4, rdy0}), 0);
    repeat (5) step();
    chk("abort_no_done", 128'(dn0 + dn4), 0);
    chk("abort_npulse", 128'(lp4.size()), 1);
    chk("abort_err", 128'({err0, err4}), 0);
    // oversize length rejected, exact MAX_LEN accepted
    clear(); go(2'b00, 32'hFFFF_FFF0);
    chk("big_err", 128'({err0, busy0}), 128'b10);
    repeat (3) step();
    chk("big_stay_idle", 128'({err0, busy0, busy4}), 128'b100);
    chk("big_npulse", 128'(lp0.size() + lp4.size()), 0);
    go(2'b00, 32'hFFFF_FF00);
    chk("max_accept", 128'({err0, busy0}), 128'b01);
    chk("max_len_out", len0, 32'hFFFF_FF00);
    abort = 1; step(); abort = 0;
    chk("max_abort", 128'(busy0), 0);
    // datapath error on the fast instance only
    clear(); dperr0 = 1; go(2'b10, 20); wait_idle(); dperr0 = 0;
    chk("dperr_err", 128'({err0, err4}), 128'b10);
    chk("dperr_npulse", 128'(lp0.size()), 1);
    chk("dperr_done", 128'({dn0[0], dn4[0]}), 128'b01);
    // abort beats start in IDLE
    abort = 1; go(2'b00, 20); abort = 0;
    chk("abort_start", 128'({busy0, err0}), 128'b01);
    // async reset while waiting for a word
    s_valid = 0; clear(); go(2'b10, 20); step(); step();
    chk("prerst_fetch", 128'({rdy0, ty0, err0}), 128'b1100);
    rst = 1; #1;
    chk("rst_outs0", outs0(), 0);
    chk("rst_outs4", outs4(), 0);
    step(); rst = 0; s_valid = 1;
    // clean job afterwards
    clear(); go(2'b00, 20); wait_idle();
    chk("post_npulse", 128'(lp0.size()), 2);
    chk("post_done", 128'({dn0[0], err0}), 128'b10);
    chk("post_pos1", lp0[1], 16);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
